// File: rtl/array_add_pkg.sv
// Shared widths, depth and operand-pattern functions for the array accumulator.
package array_add_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  // Operand A: the element index, zero-extended.
  function automatic logic [DATA_W-1:0] a_pattern(input logic [IDX_W-1:0] i);
    return DATA_W'(i);
  endfunction

  // Operand B: the element index placed in the upper half-word.
  function automatic logic [DATA_W-1:0] b_pattern(input logic [IDX_W-1:0] i);
    return DATA_W'(i) << 16;
  endfunction

endpackage

// File: rtl/array_add_mem.sv
// DEPTH x DATA_W register array: synchronous clear, one write port, two async read ports.
module array_add_mem
  import array_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_a_i,
  output logic [DATA_W-1:0] rd_a_c_o,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rd_b_c_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_a_c_o = mem_q[raddr_a_i];
  assign rd_b_c_o = mem_q[raddr_b_i];

endmodule

// File: rtl/array_add_top.sv
// Walks C[i] += A[i] + B[i] one element per enabled cycle; sum shows the last element written.
// Define ARRAY_ADD_SATURATE_EN to clamp accumulators at all-ones instead of wrapping.
module array_add_top #(
  parameter int unsigned DATA_W = array_add_pkg::DATA_W,
  parameter int unsigned IDX_W  = array_add_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [IDX_W-1:0]  index,
  output logic [DATA_W-1:0] sum
);

  logic [IDX_W-1:0]  index_q;
  logic [IDX_W-1:0]  index_d;
  logic [IDX_W-1:0]  prev_idx;
  logic [DATA_W-1:0] a_cur;
  logic [DATA_W-1:0] b_cur;
  logic [DATA_W-1:0] c_cur;
  logic [DATA_W-1:0] acc_next;
  logic              we;

  // A and B are fixed patterns, so they are generated as constant logic.
  assign a_cur    = array_add_pkg::a_pattern(index_q);
  assign b_cur    = array_add_pkg::b_pattern(index_q);
  assign prev_idx = index_q - IDX_W'(1);
  assign we       = run & ~rst;

`ifdef ARRAY_ADD_SATURATE_EN
  logic [DATA_W:0] acc_full;
  assign acc_full = {1'b0, c_cur} + {1'b0, a_cur} + {1'b0, b_cur};
  assign acc_next = acc_full[DATA_W] ? '1 : acc_full[DATA_W-1:0];
`else
  assign acc_next = c_cur + a_cur + b_cur;
`endif

  always_comb begin
    index_d = index_q;
    if (run) begin
      index_d = index_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  array_add_mem u_c_mem (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we),
    .waddr_i   (index_q),
    .wdata_i   (acc_next),
    .raddr_a_i (index_q),
    .rd_a_c_o  (c_cur),
    .raddr_b_i (prev_idx),
    .rd_b_c_o  (sum)
  );

  assign index = index_q;

endmodule

// File: tb/tb_array_add_top.sv
// Directed bench for array_add_top with a per-cycle reference model and literal checkpoints.
module tb_array_add_top;

`ifdef ARRAY_ADD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  index;
  logic [31:0] sum;

  int n_cmp;
  int n_bad;

  // Reference state: plain integer arithmetic on the accumulator array.
  longint c_m [256];
  int     idx_m;
  bit     model_ok;

  array_add_top dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .index (index),
    .sum   (sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    longint t;
    if (rst) begin
      for (int i = 0; i < 256; i++) c_m[i] = 0;
      idx_m    = 0;
      model_ok = 1'b1;
    end else if (run && model_ok) begin
      t = c_m[idx_m] + longint'(idx_m) + (longint'(idx_m) * 65536);
      if (t > 64'hFFFF_FFFF) t = SAT ? 64'hFFFF_FFFF : (t - 64'h1_0000_0000);
      c_m[idx_m] = t;
      idx_m = (idx_m + 1) % 256;
    end
  end

  // Every cycle after reset, outputs must match the model.
  always @(negedge clk) begin
    if (model_ok) begin
      n_cmp++;
      if (index !== 8'(idx_m)) begin
        n_bad++;
        $display("FAIL model_index t=%0t: got %0d want %0d", $time, index, idx_m);
      end
      n_cmp++;
      if (sum !== 32'(c_m[(idx_m + 255) % 256])) begin
        n_bad++;
        $display("FAIL model_sum t=%0t: got %h want %h", $time, sum,
                 32'(c_m[(idx_m + 255) % 256]));
      end
    end
  end

  task automatic drive(input logic r, input logic u, input int n);
    rst = r;
    run = u;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_lit(input string name, input logic [7:0] exp_idx,
                           input logic [31:0] exp_sum);
    n_cmp++;
    if (index !== exp_idx) begin
      n_bad++;
      $display("FAIL %s index: got %h want %h", name, index, exp_idx);
    end
    n_cmp++;
    if (sum !== exp_sum) begin
      n_bad++;
      $display("FAIL %s sum: got %h want %h", name, sum, exp_sum);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    model_ok = 1'b0;
    idx_m    = 0;
    rst      = 1'b1;
    run      = 1'b0;

    drive(1'b1, 1'b0, 2);
    check_lit("reset", 8'h00, 32'h0000_0000);

    drive(1'b0, 1'b1, 1);
    check_lit("run1", 8'h01, 32'h0000_0000);
    drive(1'b0, 1'b1, 1);
    check_lit("run2", 8'h02, 32'h0001_0001);
    drive(1'b0, 1'b1, 2);
    check_lit("run4", 8'h04, 32'h0003_0003);

    drive(1'b0, 1'b0, 10);
    check_lit("hold", 8'h04, 32'h0003_0003);
    drive(1'b0, 1'b1, 1);
    check_lit("resume", 8'h05, 32'h0004_0004);

    drive(1'b0, 1'b1, 251);
    check_lit("pass1", 8'h00, 32'h00FF_00FF);
    drive(1'b0, 1'b1, 256);
    check_lit("pass2", 8'h00, 32'h01FE_01FE);

    // Reset mid-pass with run high: reset must win and clear C.
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 100);
    check_lit("mid100", 8'h64, 32'h0063_0063);
    drive(1'b1, 1'b1, 1);
    check_lit("rst_run", 8'h00, 32'h0000_0000);
    drive(1'b0, 1'b1, 5);
    check_lit("revisit4", 8'h05, 32'h0004_0004);
    drive(1'b0, 1'b1, 1);
    check_lit("revisit5", 8'h06, 32'h0005_0005);

    // Long run to the overflow boundary.
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 65792);
    check_lit("pass257", 8'h00, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 256);
    check_lit("pass258", 8'h00, SAT ? 32'hFFFF_FFFF : 32'h00FF_00FE);

    drive(1'b0, 1'b0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/array_add_top.md
ARRAY_ADD_TOP -- requirements
Module: array_add_top

Interface
REQ-001 Parameter DATA_W, default 32, word width of all arrays and of sum; fixed, no other value supported.
REQ-002 Parameter IDX_W, default 8, index width; array depth is 2**IDX_W = 256 entries.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port run  input  1  advance enable; one array element processed per cycle while high.
REQ-006 Port index  output  IDX_W  current element pointer (registered).
REQ-007 Port sum  output  DATA_W  accumulator word of the most recently processed element.

Function
REQ-008 Three internal 256 x 32 arrays SHALL exist: A, B (operands) and C (accumulators).
REQ-009 Operand contents SHALL be A[i] = i and B[i] = i << 16, zero-extended to 32 bits, for i = 0..255.
REQ-010 When run=1 and rst=0, on each rising edge C[index] SHALL become C[index] + A[index] + B[index], and index SHALL become index+1.
REQ-011 Index SHALL wrap 255 -> 0 with no stall or gap cycle; the next pass continues accumulating into C.
REQ-012 Addition SHALL be modulo 2**32, with carry discarded, unless the configuration feature is enabled.
REQ-013 When run=0, index and all of C SHALL hold their values.
REQ-014 sum SHALL be combinational: C[(index - 1) mod 256], so it reflects the element written on the previous active edge with zero added latency.
REQ-015 Only one C entry SHALL be written per cycle; A and B are read-only after reset.
REQ-016 When rst and run are both high, rst SHALL win and no accumulation occurs.

Reset
REQ-017 While rst=1 at a rising edge: index SHALL become 0, every C[i] SHALL become 0, and A and B SHALL be (re)loaded per REQ-009.
REQ-018 After reset, sum SHALL read C[255] = 0x00000000.
REQ-019 Reset asserted mid-pass SHALL discard all partial accumulation on the next edge.

Configuration
REQ-020 Macro ARRAY_ADD_SATURATE_EN: when defined, an accumulation whose true result exceeds 0xFFFFFFFF SHALL store 0xFFFFFFFF and then hold there on later passes.
REQ-021 When the macro is undefined, the accumulation SHALL wrap modulo 2**32; all other behaviour is identical.

Structure
REQ-022 Package array_add_pkg SHALL hold DATA_W, IDX_W, DEPTH=256 and the operand-pattern functions for A[i] and B[i].
REQ-023 One sub-module, array_add_mem, SHALL implement a 256 x DATA_W register array with synchronous reset, one write port and two asynchronous read ports; it SHALL be instantiated for C.
REQ-024 A and B MAY be reset-loaded registers or constant logic; both forms SHALL give identical results.

Verification
REQ-025 Assert rst for 2 cycles -> index=0x00, sum=0x00000000.
REQ-026 Release rst with run=1 -> after 1 cycle index=1, sum=0x00000000; after 2 cycles index=2, sum=0x00010001; after 4 cycles index=4, sum=0x00030003.
REQ-027 Drop run for 10 cycles after 4 active cycles -> index stays 4 and sum stays 0x00030003; raising run again resumes at index 4.
REQ-028 Run continuously:
- 256 cycles -> index=0, sum=0x00FF00FF.
- 512 cycles -> index=0, sum=0x01FE01FE.
REQ-029 Assert rst together with run=1 at cycle 100 -> next edge gives index=0 and sum=0; C[5] then reads 0 on its next visit before being written.
REQ-030 Run 257 passes (65792 cycles) -> sum=0xFFFFFFFF. Run 258 passes (66048 cycles) -> sum=0x00FF00FE without ARRAY_ADD_SATURATE_EN, sum=0xFFFFFFFF with it.
